// File: rtl/sw_mem_pkg.sv
// rtl/sw_mem_pkg.sv - shared beat geometry, FSM encoding and AXI len helper
package sw_mem_pkg;

    localparam int BEAT_BYTES     = 32;
    localparam int BEAT_SHIFT     = 5;
    localparam int BOUNDARY_BYTES = 4096;
    localparam int BURST_W        = 9;

    // Burst sizes reach 256 beats, one more than an 8-bit AXI len can show.
    typedef logic [BURST_W-1:0] burst_beats_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic logic [7:0] axi_len(input burst_beats_t beats);
        return 8'(beats - burst_beats_t'(1));
    endfunction

endpackage

// File: rtl/rd_burst_len_calc.sv
// rtl/rd_burst_len_calc.sv - beats in the next burst: min(remaining, MAX_BEATS, room to boundary)
module rd_burst_len_calc #(
    parameter int ADDR_WIDTH     = 33,
    parameter int BEATS_WIDTH    = 16,
    parameter int MAX_BEATS      = 64,
    parameter int BOUNDARY_BYTES = sw_mem_pkg::BOUNDARY_BYTES
) (
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [BEATS_WIDTH-1:0] remaining,
    output sw_mem_pkg::burst_beats_t beats
);
    import sw_mem_pkg::*;

    logic [63:0] offset;
    logic [63:0] room;
    logic [63:0] lim;

    always_comb begin
        offset = 64'(addr & ADDR_WIDTH'(BOUNDARY_BYTES - 1));
        room   = (64'(BOUNDARY_BYTES) - offset) >> BEAT_SHIFT;
        lim    = 64'(MAX_BEATS);
        if (room < lim) begin
            lim = room;
        end
        if (64'(remaining) < lim) begin
            lim = 64'(remaining);
        end
        beats = burst_beats_t'(lim);
    end

endmodule

// File: rtl/rd_burst_splitter.sv
// rtl/rd_burst_splitter.sv - splits one read request into AXI-legal INCR bursts and counts returned beats
module rd_burst_splitter #(
    parameter int ADDR_WIDTH     = 33,
    parameter int DATA_WIDTH     = 256,
    parameter int ID_WIDTH       = 6,
    parameter int BEATS_WIDTH    = 16,
    parameter int MAX_BEATS      = 64,
    parameter int BOUNDARY_BYTES = sw_mem_pkg::BOUNDARY_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ID_WIDTH-1:0]    req_id_in,
    input  logic [ADDR_WIDTH-1:0]  req_addr_in,
    input  logic [BEATS_WIDTH-1:0] req_beats_in,
    input  logic                   req_valid_in,
    output logic                   req_rdy_out,
    output logic [ID_WIDTH-1:0]    rd_id_out,
    output logic [ADDR_WIDTH-1:0]  rd_addr_out,
    output logic [7:0]             rd_len_out,
    output logic                   rd_info_valid_out,
    input  logic                   rd_info_rdy_in,
    input  logic [DATA_WIDTH-1:0]  rd_data_in,
    input  logic                   rd_data_valid_in,
    output logic                   rd_data_rdy_out,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_valid_out,
    input  logic                   data_rdy_in,
    output logic                   req_done_out
);
    import sw_mem_pkg::*;

    logic [1:0]             state;
    logic [BEATS_WIDTH-1:0] rem;
    logic [BEATS_WIDTH-1:0] exp_beats;
    logic [BEATS_WIDTH-1:0] got;
    burst_beats_t           cur_beats;
    burst_beats_t           calc_beats;
    logic [ADDR_WIDTH-1:0]  aligned_addr;
    logic [ADDR_WIDTH-1:0]  next_addr;
    logic [ADDR_WIDTH-1:0]  calc_addr;
    logic [BEATS_WIDTH-1:0] next_rem;
    logic [BEATS_WIDTH-1:0] calc_rem;
    logic                   active;
    logic                   beat_fire;
    logic                   got_inc;

    assign active          = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign data_out        = rd_data_in;
    assign data_valid_out  = rd_data_valid_in & active;
    assign rd_data_rdy_out = data_rdy_in & active;
    assign beat_fire       = data_valid_out & data_rdy_in;
    assign got_inc         = beat_fire && (got != exp_beats);
    assign req_rdy_out     = (state == ST_IDLE) && !req_done_out;

    assign aligned_addr = req_addr_in & ~ADDR_WIDTH'(BEAT_BYTES - 1);
    assign next_addr    = rd_addr_out + (ADDR_WIDTH'(cur_beats) << BEAT_SHIFT);
    assign next_rem     = rem - BEATS_WIDTH'(cur_beats);

    // The calculator serves both the first burst (from the request) and every
    // follow-on burst, so the next one is ready the cycle after a handshake.
    assign calc_addr = (state == ST_IDLE) ? aligned_addr : next_addr;
    assign calc_rem  = (state == ST_IDLE) ? req_beats_in : next_rem;

    rd_burst_len_calc #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .BEATS_WIDTH   (BEATS_WIDTH),
        .MAX_BEATS     (MAX_BEATS),
        .BOUNDARY_BYTES(BOUNDARY_BYTES)
    ) u_len_calc (
        .addr     (calc_addr),
        .remaining(calc_rem),
        .beats    (calc_beats)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_IDLE;
            rem               <= '0;
            exp_beats         <= '0;
            got               <= '0;
            cur_beats         <= '0;
            rd_id_out         <= '0;
            rd_addr_out       <= '0;
            rd_len_out        <= '0;
            rd_info_valid_out <= 1'b0;
            req_done_out      <= 1'b0;
        end else begin
            req_done_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_in && req_rdy_out) begin
                        rd_id_out <= req_id_in;
                        exp_beats <= req_beats_in;
                        got       <= '0;
                        rem       <= req_beats_in;
                        if (req_beats_in == '0) begin
                            state <= ST_DRAIN;
                        end else begin
                            state             <= ST_ISSUE;
                            rd_info_valid_out <= 1'b1;
                            rd_addr_out       <= aligned_addr;
                            rd_len_out        <= axi_len(calc_beats);
                            cur_beats         <= calc_beats;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (got_inc) begin
                        got <= got + 1'b1;
                    end
                    if (rd_info_rdy_in) begin
                        if (next_rem == '0) begin
                            rd_info_valid_out <= 1'b0;
                            rem               <= '0;
                            state             <= ST_DRAIN;
                        end else begin
                            rd_addr_out <= next_addr;
                            rd_len_out  <= axi_len(calc_beats);
                            cur_beats   <= calc_beats;
                            rem         <= next_rem;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (got_inc) begin
                        got <= got + 1'b1;
                    end
                    if (got == exp_beats) begin
                        req_done_out <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rd_burst_splitter.sv
// tb/tb_rd_burst_splitter.sv - directed self-checking bench for rd_burst_splitter
module tb_rd_burst_splitter;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   req_id_in;
    logic [32:0]  req_addr_in;
    logic [15:0]  req_beats_in;
    logic         req_valid_in;
    logic         req_rdy_out;
    logic [5:0]   rd_id_out;
    logic [32:0]  rd_addr_out;
    logic [7:0]   rd_len_out;
    logic         rd_info_valid_out;
    logic         rd_info_rdy_in;
    logic [255:0] rd_data_in;
    logic         rd_data_valid_in;
    logic         rd_data_rdy_out;
    logic [255:0] data_out;
    logic         data_valid_out;
    logic         data_rdy_in;
    logic         req_done_out;

    always #5 clk = ~clk;

    rd_burst_splitter dut (
        .clk              (clk),
        .rst              (rst),
        .req_id_in        (req_id_in),
        .req_addr_in      (req_addr_in),
        .req_beats_in     (req_beats_in),
        .req_valid_in     (req_valid_in),
        .req_rdy_out      (req_rdy_out),
        .rd_id_out        (rd_id_out),
        .rd_addr_out      (rd_addr_out),
        .rd_len_out       (rd_len_out),
        .rd_info_valid_out(rd_info_valid_out),
        .rd_info_rdy_in   (rd_info_rdy_in),
        .rd_data_in       (rd_data_in),
        .rd_data_valid_in (rd_data_valid_in),
        .rd_data_rdy_out  (rd_data_rdy_out),
        .data_out         (data_out),
        .data_valid_out   (data_valid_out),
        .data_rdy_in      (data_rdy_in),
        .req_done_out     (req_done_out)
    );

    int errors = 0;
    int checks = 0;

    logic [32:0] bq_addr[$];
    logic [7:0]  bq_len[$];
    logic [5:0]  bq_id[$];
    int          bq_cyc[$];
    int beats_got, done_cnt, accept_cyc, done_cyc, first_beat_cyc, last_beat_cyc;
    int first_valid_cyc, stable_bad, data_bad, pending, stall_cnt;
    logic rdy_at_done, rdy_after_done;
    logic [32:0] held_addr;
    logic [7:0]  held_len;
    logic [5:0]  held_id;

    // Plays Engine and arbiter for one request; records every handshake by cycle index.
    task automatic run_req(input logic [32:0] a, input logic [15:0] n, input logic [5:0] id,
                           input int stall_idx, input int stall_len, input bit toggle_rdy,
                           input int budget);
        bit accepted = 0;
        bit stalling;
        bq_addr.delete(); bq_len.delete(); bq_id.delete(); bq_cyc.delete();
        beats_got = 0; done_cnt = 0; accept_cyc = -1; done_cyc = -1;
        first_beat_cyc = -1; last_beat_cyc = -1; first_valid_cyc = -1;
        stable_bad = 0; data_bad = 0; pending = 0; stall_cnt = 0;
        rdy_at_done = 1'bx; rdy_after_done = 1'bx;
        for (int k = 0; k < budget; k++) begin
            req_valid_in     = !accepted;
            req_addr_in      = a;
            req_beats_in     = n;
            req_id_in        = id;
            data_rdy_in      = toggle_rdy ? k[0] : 1'b1;
            rd_data_valid_in = (pending > 0);
            rd_data_in       = {8{32'(k) ^ 32'hA5A5_0000}};
            stalling         = (bq_addr.size() == stall_idx) && rd_info_valid_out && (stall_cnt < stall_len);
            rd_info_rdy_in   = !stalling;
            #1;
            if (stalling) begin
                if (stall_cnt == 0) begin
                    held_addr = rd_addr_out; held_len = rd_len_out; held_id = rd_id_out;
                end else if (rd_addr_out !== held_addr || rd_len_out !== held_len || rd_id_out !== held_id) begin
                    stable_bad++;
                end
                stall_cnt++;
            end
            if (rd_info_valid_out && first_valid_cyc < 0) first_valid_cyc = k;
            if (req_valid_in && req_rdy_out) begin
                accepted = 1; accept_cyc = k;
            end
            if (data_valid_out && data_rdy_in) begin
                beats_got++; pending--;
                if (first_beat_cyc < 0) first_beat_cyc = k;
                last_beat_cyc = k;
                if (data_out !== rd_data_in) data_bad++;
            end
            if (rd_info_valid_out && rd_info_rdy_in) begin
                bq_addr.push_back(rd_addr_out); bq_len.push_back(rd_len_out);
                bq_id.push_back(rd_id_out); bq_cyc.push_back(k);
                pending += int'(rd_len_out) + 1;
            end
            if (req_done_out) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k; rdy_at_done = req_rdy_out;
                end
            end
            if (done_cyc >= 0 && k == done_cyc + 1) rdy_after_done = req_rdy_out;
            @(posedge clk); #1;
            if (done_cyc >= 0 && k >= done_cyc + 3) break;
        end
        req_valid_in = 0; rd_data_valid_in = 0; rd_info_rdy_in = 1; data_rdy_in = 1;
    endtask

    task automatic test_reset;
        checks++;
        if ({rd_info_valid_out, rd_addr_out, rd_len_out, rd_id_out, req_done_out} !== 49'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b addr=%0h len=%0h id=%0h done=%0b, expected all 0",
                     rd_info_valid_out, rd_addr_out, rd_len_out, rd_id_out, req_done_out);
        end
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        checks++;
        if (req_rdy_out !== 1'b1) begin
            errors++; $display("FAIL reset_req_rdy: got %0b expected 1", req_rdy_out);
        end
    endtask

    task automatic test_idle_data;
        rd_data_in = {8{32'hDEAD_BEEF}}; rd_data_valid_in = 1; data_rdy_in = 1;
        #1;
        checks++;
        if (rd_data_rdy_out !== 1'b0 || data_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_data_blocked: got rdy=%0b valid=%0b expected 0/0", rd_data_rdy_out, data_valid_out);
        end
        checks++;
        if (data_out !== {8{32'hDEAD_BEEF}}) begin
            errors++; $display("FAIL data_passthrough: got %0h expected %0h", data_out, {8{32'hDEAD_BEEF}});
        end
        @(posedge clk); #1;
        rd_data_valid_in = 0;
    endtask

    task automatic test_split_200;
        logic [32:0] ea[4] = '{33'h000, 33'h800, 33'h1000, 33'h1800};
        logic [7:0]  el[4] = '{8'd63, 8'd63, 8'd63, 8'd7};
        run_req(33'h0, 16'd200, 6'h2A, -1, 0, 0, 2000);
        checks++;
        if (bq_addr.size() !== 4) begin
            errors++; $display("FAIL split200_count: got %0d bursts expected 4", bq_addr.size());
        end
        for (int i = 0; i < 4 && i < bq_addr.size(); i++) begin
            checks++;
            if (bq_addr[i] !== ea[i] || bq_len[i] !== el[i] || bq_id[i] !== 6'h2A) begin
                errors++;
                $display("FAIL split200_burst%0d: got (%0h,len%0d,id%0h) expected (%0h,len%0d,id2a)",
                         i, bq_addr[i], bq_len[i], bq_id[i], ea[i], el[i]);
            end
        end
        checks++;
        if (bq_cyc.size() == 4 && !(bq_cyc[0] == accept_cyc + 1 && bq_cyc[1] == bq_cyc[0] + 1 &&
                                     bq_cyc[2] == bq_cyc[1] + 1 && bq_cyc[3] == bq_cyc[2] + 1)) begin
            errors++;
            $display("FAIL split200_back_to_back: accept=%0d bursts at %0d,%0d,%0d,%0d expected consecutive from accept+1",
                     accept_cyc, bq_cyc[0], bq_cyc[1], bq_cyc[2], bq_cyc[3]);
        end
        checks++;
        if (beats_got !== 200 || done_cnt !== 1 || done_cyc <= last_beat_cyc) begin
            errors++;
            $display("FAIL split200_done: got beats=%0d done=%0d (done@%0d last beat@%0d) expected 200 beats, 1 done after last beat",
                     beats_got, done_cnt, done_cyc, last_beat_cyc);
        end
        checks++;
        if (bq_cyc.size() != 4 || first_beat_cyc < 0 || first_beat_cyc >= bq_cyc[3]) begin
            errors++;
            $display("FAIL early_data: first beat at %0d, expected before final burst issue", first_beat_cyc);
        end
        checks++;
        if (data_bad !== 0) begin
            errors++; $display("FAIL data_path: got %0d corrupted beats expected 0", data_bad);
        end
    endtask

    task automatic test_boundary_fc0;
        run_req(33'hFC0, 16'd10, 6'h05, -1, 0, 0, 500);
        checks++;
        if (bq_addr.size() !== 2) begin
            errors++; $display("FAIL fc0_count: got %0d bursts expected 2", bq_addr.size());
        end else begin
            checks++;
            if (bq_addr[0] !== 33'hFC0 || bq_len[0] !== 8'd1 || bq_addr[1] !== 33'h1000 || bq_len[1] !== 8'd7) begin
                errors++;
                $display("FAIL fc0_bursts: got (%0h,len%0d),(%0h,len%0d) expected (fc0,len1),(1000,len7)",
                         bq_addr[0], bq_len[0], bq_addr[1], bq_len[1]);
            end
        end
        checks++;
        if (beats_got !== 10 || done_cnt !== 1) begin
            errors++; $display("FAIL fc0_done: got beats=%0d done=%0d expected 10/1", beats_got, done_cnt);
        end
    endtask

    task automatic test_zero_beats;
        run_req(33'h400, 16'd0, 6'h11, -1, 0, 0, 100);
        checks++;
        if (bq_addr.size() !== 0 || first_valid_cyc !== -1) begin
            errors++; $display("FAIL zero_no_burst: got %0d bursts expected 0", bq_addr.size());
        end
        checks++;
        if (done_cnt !== 1 || done_cyc - accept_cyc !== 2) begin
            errors++;
            $display("FAIL zero_done_timing: got done=%0d at +%0d cycles expected 1 at +2", done_cnt, done_cyc - accept_cyc);
        end
        checks++;
        if (rdy_at_done !== 1'b0 || rdy_after_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_req_rdy: got %0b on done cycle, %0b after, expected 0 then 1", rdy_at_done, rdy_after_done);
        end
    endtask

    task automatic test_stall;
        logic [32:0] ea[4] = '{33'h000, 33'h800, 33'h1000, 33'h1800};
        logic [7:0]  el[4] = '{8'd63, 8'd63, 8'd63, 8'd7};
        run_req(33'h0, 16'd200, 6'h1C, 1, 5, 1, 3000);
        checks++;
        if (stall_cnt !== 5 || stable_bad !== 0) begin
            errors++; $display("FAIL stall_stable: got %0d stall cycles, %0d changes; expected 5, 0", stall_cnt, stable_bad);
        end
        checks++;
        if (bq_addr.size() !== 4) begin
            errors++; $display("FAIL stall_count: got %0d bursts expected 4", bq_addr.size());
        end
        for (int i = 0; i < 4 && i < bq_addr.size(); i++) begin
            checks++;
            if (bq_addr[i] !== ea[i] || bq_len[i] !== el[i] || bq_id[i] !== 6'h1C) begin
                errors++;
                $display("FAIL stall_burst%0d: got (%0h,len%0d,id%0h) expected (%0h,len%0d,id1c)",
                         i, bq_addr[i], bq_len[i], bq_id[i], ea[i], el[i]);
            end
        end
        checks++;
        if (beats_got !== 200 || done_cnt !== 1) begin
            errors++; $display("FAIL stall_done: got beats=%0d done=%0d expected 200/1", beats_got, done_cnt);
        end
    endtask

    task automatic test_wrap_align;
        run_req(33'h1_FFFF_FFF5, 16'd2, 6'h3F, -1, 0, 0, 200);
        checks++;
        if (bq_addr.size() !== 2) begin
            errors++; $display("FAIL wrap_count: got %0d bursts expected 2", bq_addr.size());
        end else begin
            checks++;
            if (bq_addr[0] !== 33'h1_FFFF_FFE0 || bq_len[0] !== 8'd0 || bq_addr[1] !== 33'h0 || bq_len[1] !== 8'd0) begin
                errors++;
                $display("FAIL wrap_bursts: got (%0h,len%0d),(%0h,len%0d) expected (1ffffffe0,len0),(0,len0)",
                         bq_addr[0], bq_len[0], bq_addr[1], bq_len[1]);
            end
        end
        checks++;
        if (beats_got !== 2 || done_cnt !== 1) begin
            errors++; $display("FAIL wrap_done: got beats=%0d done=%0d expected 2/1", beats_got, done_cnt);
        end
    endtask

    task automatic test_mid_reset;
        req_id_in = 6'h09; req_addr_in = 33'h3000; req_beats_in = 16'd100; req_valid_in = 1;
        rd_info_rdy_in = 0; rd_data_valid_in = 0;
        @(posedge clk); #1;
        req_valid_in = 0;
        @(posedge clk); #1;
        checks++;
        if (rd_info_valid_out !== 1'b1) begin
            errors++; $display("FAIL pre_reset_valid: got %0b expected 1", rd_info_valid_out);
        end
        #2 rst = 0;
        #1;
        checks++;
        if ({rd_info_valid_out, rd_addr_out, rd_len_out, rd_id_out, req_done_out} !== 49'd0) begin
            errors++;
            $display("FAIL async_reset: got valid=%0b addr=%0h len=%0h id=%0h done=%0b expected all 0",
                     rd_info_valid_out, rd_addr_out, rd_len_out, rd_id_out, req_done_out);
        end
        @(posedge clk); #1;
        rst = 1; rd_info_rdy_in = 1;
        @(posedge clk); #1;
        checks++;
        if (req_rdy_out !== 1'b1) begin
            errors++; $display("FAIL post_reset_rdy: got %0b expected 1", req_rdy_out);
        end
        run_req(33'h2000, 16'd1, 6'h15, -1, 0, 0, 200);
        checks++;
        if (bq_addr.size() !== 1 || bq_addr[0] !== 33'h2000 || bq_len[0] !== 8'd0 || bq_id[0] !== 6'h15) begin
            errors++;
            $display("FAIL post_reset_burst: got %0d bursts first (%0h,len%0d) expected 1 (2000,len0)",
                     bq_addr.size(), bq_addr[0], bq_len[0]);
        end
        checks++;
        if (beats_got !== 1 || done_cnt !== 1) begin
            errors++; $display("FAIL post_reset_done: got beats=%0d done=%0d expected 1/1", beats_got, done_cnt);
        end
    endtask

    initial begin
        rst = 0;
        req_id_in = '0; req_addr_in = '0; req_beats_in = '0; req_valid_in = 0;
        rd_info_rdy_in = 1; rd_data_in = '0; rd_data_valid_in = 0; data_rdy_in = 1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_idle_data();
        test_split_200();
        test_boundary_fc0();
        test_zero_beats();
        test_stall();
        test_wrap_align();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
